// File: rtl/decode_hazard_tracker_if.sv
// Decode-side hazard bus: source/destination info from decode and the
// stall / operand-forward decisions returned to it.
interface decode_hazard_tracker_if #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
);
  logic [NB_REG-1:0] id_rs;
  logic [NB_REG-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_is_branch;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [NB_REG-1:0] id_write_reg;
  logic              stall;
  logic [1:0]        forward_A;
  logic [1:0]        forward_B;
  logic [NB_CNT-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_reg_write, id_mem_read, id_write_reg,
    input  stall, forward_A, forward_B, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_reg_write, id_mem_read, id_write_reg,
    output stall, forward_A, forward_B, stall_count
  );
endinterface

// File: rtl/decode_hazard_tracker.sv
// Shadow EX/MEM/WB destination-tag pipeline that produces the decode stall,
// decode operand forward selects and a saturating stall counter.
module decode_hazard_tracker #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  decode_hazard_tracker_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [NB_REG-1:0] dest;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
                                   dest: {NB_REG{1'b0}}};

  slot_t             ex_q, ex_d;
  slot_t             mem_q, mem_d;
  slot_t             wb_q, wb_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              stall_s;
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;
  logic              unused_wb_mem_read_s;

  // Register 0 is hard-wired, so a write to it is never a producer.
  function automatic logic slot_match(input slot_t s, input logic [NB_REG-1:0] src,
                                      input logic use_src);
    return s.valid & s.reg_write & (s.dest != {NB_REG{1'b0}}) & (s.dest == src) & use_src;
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                         input logic [NB_REG-1:0] src, input logic use_src);
    if (slot_match(m, src, use_src) && !m.mem_read) begin
      return 2'b01;
    end else if (slot_match(w, src, use_src)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  // Hazard detection and forward selection, forced idle while reset is low.
  always_comb begin
    stall_s = 1'b0;
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (!reset) begin
      stall_s = 1'b0;
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end else begin
      stall_s =
        ((slot_match(ex_q, bus.id_rs, bus.id_use_rs) ||
          slot_match(ex_q, bus.id_rt, bus.id_use_rt)) &&
         (ex_q.mem_read || bus.id_is_branch)) ||
        (bus.id_is_branch && mem_q.mem_read &&
         (slot_match(mem_q, bus.id_rs, bus.id_use_rs) ||
          slot_match(mem_q, bus.id_rt, bus.id_use_rt)));
      fwd_a_s = fwd_sel(mem_q, wb_q, bus.id_rs, bus.id_use_rs);
      fwd_b_s = fwd_sel(mem_q, wb_q, bus.id_rt, bus.id_use_rt);
    end
  end

  // Next-state for the shadow slots and stall counter; everything holds when disabled.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (enable) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (stall_s) begin
        ex_d = SLOT_EMPTY;
      end else begin
        ex_d = '{valid: 1'b1, reg_write: bus.id_reg_write,
                 mem_read: bus.id_mem_read, dest: bus.id_write_reg};
      end
      if (stall_s && (cnt_q != {NB_CNT{1'b1}})) begin
        cnt_d = cnt_q + {{(NB_CNT-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
      cnt_q <= {NB_CNT{1'b0}};
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign unused_wb_mem_read_s = wb_q.mem_read;

  assign bus.stall       = stall_s;
  assign bus.forward_A   = fwd_a_s;
  assign bus.forward_B   = fwd_b_s;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_decode_hazard_tracker.sv
// Directed-vector bench for decode_hazard_tracker: one task per scenario.
module tb_decode_hazard_tracker;

  logic clock;
  logic reset;
  logic enable;
  int   n_cmp;
  int   n_err;

  decode_hazard_tracker_if #(.NB_REG(5), .NB_CNT(16)) bus ();

  decode_hazard_tracker #(.NB_REG(5), .NB_CNT(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic br, input logic rw, input logic mr,
                       input logic [4:0] wr);
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_use_rs    = urs;
    bus.id_use_rt    = urt;
    bus.id_is_branch = br;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_write_reg = wr;
    #1;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    drive(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8);
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall got=%b exp=0", bus.stall);
    end
    n_cmp++;
    if (bus.forward_A !== 2'b00 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL reset_fwd got=%b/%b exp=00/00", bus.forward_A, bus.forward_B);
    end
    step();
    n_cmp++;
    if (bus.stall_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count got=%0d exp=0", bus.stall_count);
    end
    reset = 1'b1;
    nop();
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b00) begin
      n_err++; $display("FAIL reset_empty got=%b/%b exp=0/00", bus.stall, bus.forward_A);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8);
    step();
    drive(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_err++; $display("FAIL lu_stall got=%b exp=1", bus.stall);
    end
    step();
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b00 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL lu_mem got=%b/%b/%b exp=0/00/00", bus.stall, bus.forward_A, bus.forward_B);
    end
    n_cmp++;
    if (bus.stall_count !== 16'd1) begin
      n_err++; $display("FAIL lu_count got=%0d exp=1", bus.stall_count);
    end
    step();
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b10 || bus.forward_B !== 2'b10) begin
      n_err++; $display("FAIL lu_wb got=%b/%b/%b exp=0/10/10", bus.stall, bus.forward_A, bus.forward_B);
    end
  endtask

  task automatic test_alu_branch();
    do_reset();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3);
    step();
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_err++; $display("FAIL ab_stall got=%b exp=1", bus.stall);
    end
    step();
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b01 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL ab_fwd got=%b/%b/%b exp=0/01/00", bus.stall, bus.forward_A, bus.forward_B);
    end
    n_cmp++;
    if (bus.stall_count !== 16'd1) begin
      n_err++; $display("FAIL ab_count got=%0d exp=1", bus.stall_count);
    end
  endtask

  task automatic test_load_branch();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
    step();
    drive(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.stall !== 1'b1) begin
        n_err++; $display("FAIL lb_stall%0d got=%b exp=1", i, bus.stall);
      end
      step();
    end
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b10 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL lb_fwd got=%b/%b/%b exp=0/10/00", bus.stall, bus.forward_A, bus.forward_B);
    end
    n_cmp++;
    if (bus.stall_count !== 16'd2) begin
      n_err++; $display("FAIL lb_count got=%0d exp=2", bus.stall_count);
    end
  endtask

  task automatic test_reg0_priority();
    do_reset();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
    step();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b00 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL r0 got=%b/%b/%b exp=0/00/00", bus.stall, bus.forward_A, bus.forward_B);
    end
    do_reset();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);
    step();
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);
    step();
    nop();
    step();
    drive(5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10);
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b01 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL prio got=%b/%b/%b exp=0/01/00", bus.stall, bus.forward_A, bus.forward_B);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3);
    step();
    drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b00 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL b2b_ex got=%b/%b/%b exp=0/00/00", bus.stall, bus.forward_A, bus.forward_B);
    end
    step();
    drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b01 || bus.forward_B !== 2'b01) begin
      n_err++; $display("FAIL b2b_same got=%b/%b/%b exp=0/01/01", bus.stall, bus.forward_A, bus.forward_B);
    end
  endtask

  task automatic test_enable();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8);
    step();
    drive(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (bus.stall !== 1'b1 || bus.stall_count !== 16'd0) begin
        n_err++; $display("FAIL en_hold%0d got=%b/%0d exp=1/0", i, bus.stall, bus.stall_count);
      end
    end
    enable = 1'b1;
    step();
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.stall_count !== 16'd1) begin
      n_err++; $display("FAIL en_release got=%b/%0d exp=0/1", bus.stall, bus.stall_count);
    end
    step();
    n_cmp++;
    if (bus.stall_count !== 16'd1) begin
      n_err++; $display("FAIL en_count got=%0d exp=1", bus.stall_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
    step();
    drive(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    n_cmp++;
    if (bus.stall !== 1'b1 || bus.stall_count !== 16'd1) begin
      n_err++; $display("FAIL rm_pre got=%b/%0d exp=1/1", bus.stall, bus.stall_count);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b00 || bus.forward_B !== 2'b00) begin
      n_err++; $display("FAIL rm_force got=%b/%b/%b exp=0/00/00", bus.stall, bus.forward_A, bus.forward_B);
    end
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.forward_A !== 2'b00 || bus.stall_count !== 16'd0) begin
      n_err++; $display("FAIL rm_after got=%b/%b/%0d exp=0/00/0", bus.stall, bus.forward_A, bus.stall_count);
    end
    step();
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.stall_count !== 16'd0) begin
      n_err++; $display("FAIL rm_settle got=%b/%0d exp=0/0", bus.stall, bus.stall_count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    enable = 1'b1;
    test_reset();
    test_load_use();
    test_alu_branch();
    test_load_branch();
    test_reg0_priority();
    test_back_to_back();
    test_enable();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
